// File: rtl/present_key_schedule_if.sv
// ----------------------------------------------------------------------------
// present_key_schedule_if
//
// Purpose: bundles the load/advance handshake and the round-key result bus of
// the PRESENT-80 key-schedule generator.
//
// Signals:
//   key_load  - one-cycle strobe, capture key_in as K1
//   key_in    - 80-bit master key
//   advance   - consumer has used the current key, step to the next one
//   keyout    - current round key
//   round     - index of the key on keyout (0 together with done means K32)
//   key_valid - keyout holds a valid key
//   done      - keyout holds K32, schedule exhausted
//
// Modports:
//   master - the side that loads keys and consumes round keys
//   slave  - the key-schedule generator itself
// ----------------------------------------------------------------------------
interface present_key_schedule_if #(
    parameter int KEY_W = 80
);
    logic             key_load;
    logic [KEY_W-1:0] key_in;
    logic             advance;
    logic [KEY_W-1:0] keyout;
    logic [4:0]       round;
    logic             key_valid;
    logic             done;

    modport master (
        output key_load, key_in, advance,
        input  keyout, round, key_valid, done
    );

    modport slave (
        input  key_load, key_in, advance,
        output keyout, round, key_valid, done
    );
endinterface

// File: rtl/present_key_schedule.sv
// ----------------------------------------------------------------------------
// present_key_schedule
//
// Purpose: sequential PRESENT-80 key schedule. Holds the key in one 80-bit
// register updated in place and produces K1..K32, one step per accepted
// advance. All outputs come straight from registers.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - present_key_schedule_if.slave (key_load, key_in, advance in;
//           keyout, round, key_valid, done out)
//
// Parameters:
//   KEY_W  - key width, only 80 is supported
//   ROUNDS - number of round keys produced (32)
// ----------------------------------------------------------------------------
module present_key_schedule #(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    present_key_schedule_if.slave  bus
);

    // Advancing from this round produces the final key and exhausts the schedule.
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic [4:0]       round_q;
    logic             valid_q;
    logic             done_q;

    logic [KEY_W-1:0] rot;
    logic [KEY_W-1:0] key_next;

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Next key: rotate left by 61, S-box the top nibble, then fold the current
    // round counter into bits 19:15. The counter before increment is used, so
    // the step to K32 still mixes in 31.
    assign rot      = {key_q[18:0], key_q[79:19]};
    assign key_next = {sbox(rot[79:76]), rot[75:20], rot[19:15] ^ round_q, rot[14:0]};

    // Schedule control. A load always wins, even over a simultaneous advance,
    // and restarts from K1 regardless of where the schedule was. Advances are
    // only honoured while running; idle and exhausted schedules ignore them.
    // The 5-bit round counter naturally wraps to 0 when K32 is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.key_load) begin
            state   <= ST_RUN;
            key_q   <= bus.key_in;
            round_q <= 5'd1;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (bus.advance && state == ST_RUN) begin
            key_q   <= key_next;
            round_q <= round_q + 5'd1;
            if (round_q == LAST_ROUND) begin
                state  <= ST_DONE;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.keyout    = key_q;
    assign bus.round     = round_q;
    assign bus.key_valid = valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_present_key_schedule.sv
// ----------------------------------------------------------------------------
// tb_present_key_schedule
//
// Purpose: self-checking bench for present_key_schedule. Combines a table of
// hand-derived vectors, directed multi-cycle sequences (reset, full run,
// priority restart, reset mid-run) and randomized traffic checked against a
// behavioural model of the key schedule.
// ----------------------------------------------------------------------------
module tb_present_key_schedule;

    logic clk;
    logic rst_n;

    present_key_schedule_if #(.KEY_W(80)) bus ();

    present_key_schedule #(
        .KEY_W  (80),
        .ROUNDS (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural model: the key in use and which key it is (1..32, 0 = none).
    logic [79:0] m_key;
    int          m_num;

    logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // One key-schedule step, from the algorithm's rotate/substitute/xor rules.
    function automatic logic [79:0] model_next(input logic [79:0] k, input int i);
        logic [79:0] r;
        r = (k << 61) | (k >> 19);
        r[79:76] = sbox_tab[r[79:76]];
        r = r ^ (80'(i) << 15);
        return r;
    endfunction

    function automatic void model_apply(input logic load, input logic [79:0] key, input logic adv);
        if (load) begin
            m_key = key;
            m_num = 1;
        end else if (adv && m_num >= 1 && m_num < 32) begin
            m_key = model_next(m_key, m_num);
            m_num = m_num + 1;
        end
    endfunction

    function automatic void model_reset();
        m_key = '0;
        m_num = 0;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then drop the strobes.
    task automatic applyStimulus(input logic load, input logic [79:0] key, input logic adv);
        bus.key_load = load;
        bus.key_in   = key;
        bus.advance  = adv;
        @(posedge clk);
        #1;
        bus.key_load = 1'b0;
        bus.advance  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [79:0] exp_key,
                               input logic [4:0] exp_round, input logic exp_valid,
                               input logic exp_done);
        n_compared++;
        if (bus.keyout !== exp_key || bus.round !== exp_round ||
            bus.key_valid !== exp_valid || bus.done !== exp_done) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got key=%h round=%0d valid=%b done=%b, expected key=%h round=%0d valid=%b done=%b",
                     name, bus.keyout, bus.round, bus.key_valid, bus.done,
                     exp_key, exp_round, exp_valid, exp_done);
        end
    endtask

    task automatic check_model(input string name);
        checkOutput(name, m_key, 5'(m_num % 32), (m_num != 0), (m_num == 32));
    endtask

    task automatic step_and_check(input string name, input logic load,
                                  input logic [79:0] key, input logic adv);
        applyStimulus(load, key, adv);
        model_apply(load, key, adv);
        check_model(name);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge.
    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput(name, 80'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        load;
        logic [79:0] key;
        logic        adv;
        logic [79:0] exp_key;
        logic [4:0]  exp_round;
        logic        exp_valid;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [79:0] rkey;

        vecs.push_back('{"zero_load",  1'b1, 80'h0, 1'b0, 80'h0,                      5'd1, 1'b1, 1'b0});
        vecs.push_back('{"zero_k2",    1'b0, 80'h0, 1'b1, 80'hC0000000000000008000,   5'd2, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{"hold_k2",  1'b0, 80'h0, 1'b0, 80'hC0000000000000008000, 5'd2, 1'b1, 1'b0});
        vecs.push_back('{"zero_k3",    1'b0, 80'h0, 1'b1, 80'h50001800000000010000,   5'd3, 1'b1, 1'b0});
        vecs.push_back('{"prio_load",  1'b1, 80'h0123456789ABCDEF0123, 1'b1,
                         80'h0123456789ABCDEF0123, 5'd1, 1'b1, 1'b0});
        vecs.push_back('{"reload_adv", 1'b1, 80'h0, 1'b1, 80'h0,                      5'd1, 1'b1, 1'b0});
        vecs.push_back('{"after_rl",   1'b0, 80'h0, 1'b1, 80'hC0000000000000008000,   5'd2, 1'b1, 1'b0});

        bus.key_load = 1'b0;
        bus.key_in   = '0;
        bus.advance  = 1'b0;
        rst_n        = 1'b0;
        model_reset();

        #12;
        checkOutput("por_state", 80'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-cycle with a key loaded, then advances while idle.
        step_and_check("pre_reset_load", 1'b1, 80'hA5A5A5A5A5A5A5A5A5A5, 1'b0);
        async_reset("midcycle_reset");
        for (int i = 0; i < 3; i++)
            step_and_check("idle_adv", 1'b0, 80'hFFFF, 1'b1);

        // Hand-derived vector table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].load, vecs[i].key, vecs[i].adv);
            model_apply(vecs[i].load, vecs[i].key, vecs[i].adv);
            checkOutput(vecs[i].name, vecs[i].exp_key, vecs[i].exp_round,
                        vecs[i].exp_valid, vecs[i].exp_done);
        end

        // Full run from the all-ones key with continuous advance.
        step_and_check("ff_load", 1'b1, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b0);
        bus.advance = 1'b1;
        for (int i = 0; i < 31; i++) begin
            @(posedge clk);
            #1;
            model_apply(1'b0, '0, 1'b1);
            check_model("ff_run");
        end
        checkOutput("ff_k32", m_key, 5'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            model_apply(1'b0, '0, 1'b1);
            check_model("ff_done_hold");
        end
        bus.advance = 1'b0;

        // Restart with load+advance together at round 17.
        rkey = {$urandom, $urandom, $urandom};
        step_and_check("r17_load", 1'b1, rkey, 1'b0);
        for (int i = 0; i < 16; i++)
            step_and_check("r17_adv", 1'b0, '0, 1'b1);
        checkOutput("r17_reached", m_key, 5'd17, 1'b1, 1'b0);
        applyStimulus(1'b1, 80'h0, 1'b1);
        model_apply(1'b1, 80'h0, 1'b1);
        checkOutput("r17_restart", 80'h0, 5'd1, 1'b1, 1'b0);

        // Reset mid-run at round 9, then advance must do nothing until a load.
        for (int i = 0; i < 8; i++)
            step_and_check("r9_adv", 1'b0, '0, 1'b1);
        checkOutput("r9_reached", m_key, 5'd9, 1'b1, 1'b0);
        async_reset("r9_reset");
        for (int i = 0; i < 2; i++)
            step_and_check("r9_idle_adv", 1'b0, '0, 1'b1);
        step_and_check("r9_reload", 1'b1, 80'h0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic ld;
            logic ad;
            ld   = ($urandom_range(0, 24) == 0);
            ad   = ($urandom_range(0, 3) != 0);
            rkey = {$urandom, $urandom, $urandom};
            step_and_check("random", ld, rkey, ad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/present_key_schedule.md
Name: present_key_schedule

Overview:
Sequential PRESENT-80 key-schedule generator. It sits directly upstream of the round-key addition stage, and its keyout bus feeds that stage's 80-bit key input. It produces one 80-bit round-key register value per round, K1..K32, and advances under a load/advance handshake. Key material is held in a single 80-bit register that is updated in place.

Parameters:
KEY_W, 80, key register width (fixed for PRESENT-80; other values unsupported)
ROUNDS, 32, number of round keys produced (K1..K32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_load  input  1  one-cycle strobe; capture key_in as K1
key_in  input  80  master key
advance  input  1  downstream consumed current key; step to next round
keyout  output  80  current round-key register K_round
round  output  5  index of the key on keyout (1..31; wraps to 0 for K32, see below)
key_valid  output  1  keyout holds a valid key
done  output  1  keyout holds K32; schedule exhausted

Behaviour:
- Reset (rst_n low, asynchronous):
  - keyout = 0, round = 0, key_valid = 0, done = 0.
  - All outputs are registered and there is no combinational path from inputs to outputs.
- Load:
  - On a clk edge with key_load = 1: keyout <= key_in, round <= 1, key_valid <= 1, done <= 0.
  - Latency is 1 cycle.
- Load has priority:
  - If key_load and advance are both high, the load wins and advance is ignored.
  - key_load mid-schedule aborts the current schedule and restarts from K1.
- Advance:
  - Acts only when key_valid = 1, done = 0 and key_load = 0.
  - Next key from current key K with counter i = round (1..31), in this order:
    1. r = K rotated left by 61 bits, i.e. r[79:0] = {K[18:0], K[79:19]}.
    2. r[79:76] = S(r[79:76]), where S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
    3. r[19:15] = r[19:15] XOR i[4:0].
  - Result: keyout <= r and round <= i+1.
- States (encoded by key_valid/done):
  - IDLE (key_valid=0): advance is ignored.
  - RUN (key_valid=1, done=0): each advance increments round.
  - DONE (key_valid=1, done=1): advance is ignored and keyout holds K32.
- Round counter wrap:
  - When advancing with round = 31, the new key is K32 and done <= 1.
  - The round field is 5 bits, so it wraps to 0 here; round = 0 with done = 1 denotes K32.
  - The value 31 is still XORed in at step 3 of that advance.
- Backpressure: with advance low, keyout and round hold indefinitely.
- Reset mid-operation: returns to IDLE immediately and asynchronously; the previous key is lost.
- One update per cycle maximum; back-to-back advance yields one new key every cycle.

Test Plan:
1. Reset then idle: assert rst_n=0 mid-cycle -> keyout=0, round=0, key_valid=0, done=0 immediately. Advance pulses while idle -> no change.
2. Zero key: key_load with key_in=0 -> keyout=0, round=1. Advance -> keyout=80'hC0000000000000008000, round=2. Advance -> keyout=80'h50001800000000010000, round=3.
3. Full run: load 80'hFFFFFFFFFFFFFFFFFFFF and assert advance continuously -> round steps 1..31 then wraps to 0; done rises on the cycle K32 appears. K32 must match the C golden model, and further advances leave keyout unchanged.
4. Backpressure: load zero key, advance once, hold advance low 10 cycles -> keyout stays 80'hC0000000000000008000. Advance resumes -> 80'h50001800000000010000.
5. Restart/priority: at round=17 assert key_load and advance together with key_in=0 -> next cycle keyout=0, round=1, done=0.
6. Reset mid-run: drop rst_n at round=9 -> all outputs zero asynchronously. After release, advance does nothing until key_load.
